ahb_lsu_master: RTL and testbench
=================================

AHB_LSU_MASTER -- requirements
Module: ahb_lsu_master

Interface
REQ-001 Parameter TIMEOUT, default 15: max WAIT cycles before the transfer is aborted with an error.
REQ-002 clk  in  1  clock; all state updates on posedge clk.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  core load/store request valid.
REQ-005 req_ready  out  1  master can accept a request; high only in IDLE.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_addr  in  AHB_ADDR_WIDTH  byte address.
REQ-008 req_rwtyp  in  3  access type (byte/half/word, signed/unsigned).
REQ-009 req_wdata  in  AHB_DATA_WIDTH  store data.
REQ-010 rsp_valid  out  1  one-cycle response strobe.
REQ-011 rsp_rdata  out  AHB_DATA_WIDTH  load data; held until the next rsp_valid.
REQ-012 rsp_err  out  1  timeout error, qualified by rsp_valid.
REQ-013 haddr  out  AHB_ADDR_WIDTH  bus address with the type field embedded.
REQ-014 hwrite  out  1  transfer direction.
REQ-015 hsel  out  1  slave select, one-cycle pulse per transfer.
REQ-016 hwdata  out  AHB_DATA_WIDTH  write data.
REQ-017 hready  in  1  slave read-data-valid indication.
REQ-018 hresp  in  1  slave write-strobe acknowledge.
REQ-019 hrdata  in  AHB_DATA_WIDTH  slave read data.

Function
REQ-020 FSM states SHALL be IDLE, SEL, WAIT and RESP.
- IDLE->SEL on req_valid&&req_ready.
- SEL->WAIT unconditionally.
- WAIT->RESP on completion or timeout.
- RESP->IDLE unconditionally.
REQ-021 On accept, req_we, req_wdata and the formed address SHALL be registered; haddr={req_addr[31:30], req_rwtyp, req_addr[26:0]}, placing the type in haddr[29:27].
REQ-022 In SEL: hsel=1. In every other state: hsel=0. This prevents the slave from re-entering a transfer when it returns to its idle state.
REQ-023 haddr, hwrite and hwdata SHALL hold their registered values from SEL through RESP inclusive. In IDLE they hold the last values.
REQ-024 Read completion: hready==1 while in WAIT with hwrite==0. hrdata SHALL be captured into rsp_rdata on that edge.
REQ-025 Write completion: hresp==1 while in WAIT with hwrite==1. hready SHALL be ignored during writes, because the slave pulses hready in its address phase.
REQ-026 In WAIT, hresp during a read and hready during a write SHALL be ignored.
REQ-027 Latency: accept edge in cycle 0; SEL in cycle 1; completion seen in cycle 3; rsp_valid=1 in cycle 4 for both reads and writes against a zero-wait slave.
REQ-028 A 4-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-029 If the counter equals TIMEOUT without completion, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-030 Completion and timeout in the same cycle SHALL count as completion (rsp_err=0).
REQ-031 For writes, rsp_rdata SHALL be unchanged and rsp_err=0.
REQ-032 req_ready=0 in SEL, WAIT and RESP. The earliest next accept is cycle 5, giving one transfer per 5 cycles back-to-back.
REQ-033 rsp_valid SHALL be high exactly one cycle per accepted request.

Reset
REQ-034 On rstn low, at any time including mid-transfer, the FSM SHALL go to IDLE and all outputs SHALL reset to 0, except req_ready, which SHALL be 1 after reset.
REQ-035 An in-flight request SHALL be dropped with no rsp_valid.

Structure
REQ-036 AHB_ADDR_WIDTH and AHB_DATA_WIDTH (both 32) SHALL come from const_defines.svh.
REQ-037 The FSM state enum and the rwtyp encodings SHALL live in shared package ahb_pkg.
REQ-038 The block SHALL be a single module with no sub-module; the timeout counter is inline.

Verification
REQ-039 Load, addr 0x0000_0010, rwtyp 3'b010, slave model returns 0xDEADBEEF -> haddr=0x1000_0010, hsel pulsed one cycle, rsp_valid in cycle 4, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-040 Store, addr 0x0000_0020, wdata 0x1234_5678, rwtyp 3'b000 -> hwrite=1, hwdata stable from SEL through RESP, hready pulse in cycle 2 ignored, rsp_valid in cycle 4.
REQ-041 Unresponsive slave (hready=hresp=0) -> rsp_valid with rsp_err=1 and rsp_rdata=0 after TIMEOUT WAIT cycles; hsel never re-asserted.
REQ-042 req_valid held high for 3 requests -> exactly 3 hsel pulses and 3 rsp_valid strobes, spaced 5 cycles apart.
REQ-043 rstn asserted in WAIT -> outputs 0 immediately; no rsp_valid; next request completes normally.
REQ-044 Read with hresp=1 and hready=0 in WAIT, then hready=1 two cycles later -> completion only on the hready edge.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB definitions: bus widths, master FSM state encoding, load/store
// access-type (rwtyp) encodings and the helper that embeds the access type
// into the bus address.
`include "const_defines.svh"

package ahb_pkg;

  localparam int AHB_ADDR_WIDTH = `AHB_ADDR_WIDTH;
  localparam int AHB_DATA_WIDTH = `AHB_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } ahb_state_e;

  // rwtyp[2] = 1 selects zero-extension, rwtyp[1:0] selects the size
  localparam logic [2:0] RWTYP_BYTE   = 3'b000;
  localparam logic [2:0] RWTYP_HALF   = 3'b001;
  localparam logic [2:0] RWTYP_WORD   = 3'b010;
  localparam logic [2:0] RWTYP_BYTE_U = 3'b100;
  localparam logic [2:0] RWTYP_HALF_U = 3'b101;

  // The slave decodes the access type from address bits [29:27], so those
  // three bits of the core address are replaced by rwtyp.
  function automatic logic [AHB_ADDR_WIDTH-1:0] form_haddr(
    input logic [AHB_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                rwtyp
  );
    return {addr[31:30], rwtyp, addr[26:0]};
  endfunction

endpackage

// File: rtl/const_defines.svh
// Global bus widths shared across the codebase.
`ifndef CONST_DEFINES_SVH
`define CONST_DEFINES_SVH

`define AHB_ADDR_WIDTH 32
`define AHB_DATA_WIDTH 32

`endif

// File: rtl/ahb_lsu_master.sv
// ahb_lsu_master: turns single core load/store requests into one AHB-style
// transfer at a time (IDLE -> SEL -> WAIT -> RESP) with a wait-state timeout.
//
// Ports
//   clk, rstn             clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_addr,
//   req_rwtyp, req_wdata  request payload (store/load, address, type, data)
//   rsp_valid             one-cycle response strobe per accepted request
//   rsp_rdata, rsp_err    load data (held between strobes) and timeout flag
//   haddr, hwrite, hwdata registered bus address/direction/write data
//   hsel                  one-cycle slave select pulse per transfer
//   hready                slave read-data valid (reads only)
//   hresp                 slave write acknowledge (writes only)
//   hrdata                slave read data
module ahb_lsu_master
  import ahb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AHB_ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]                req_rwtyp,
  input  logic [AHB_DATA_WIDTH-1:0] req_wdata,
  output logic                      rsp_valid,
  output logic [AHB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic [AHB_ADDR_WIDTH-1:0] haddr,
  output logic                      hwrite,
  output logic                      hsel,
  output logic [AHB_DATA_WIDTH-1:0] hwdata,
  input  logic                      hready,
  input  logic                      hresp,
  input  logic [AHB_DATA_WIDTH-1:0] hrdata
);

  // Wait counter is 4 bits wide; TIMEOUT values above 15 are truncated.
  localparam logic [3:0] TIMEOUT_CNT = TIMEOUT[3:0];

  ahb_state_e state, state_nxt;
  logic [3:0] wait_cnt;
  logic       accept;
  logic       done;
  logic       timeout;

  assign accept  = req_valid && req_ready;
  // The slave pulses hready during a write address phase and may raise hresp
  // during a read, so each direction listens only to its own completion.
  assign done    = hwrite ? hresp : hready;
  assign timeout = (wait_cnt == TIMEOUT_CNT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    hsel      = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_SEL;
      end
      ST_SEL: begin
        hsel      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (done || timeout) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture: bus-side fields hold from SEL through the next accept
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      haddr  <= '0;
      hwrite <= 1'b0;
      hwdata <= '0;
    end else if (accept) begin
      haddr  <= form_haddr(req_addr, req_rwtyp);
      hwrite <= req_we;
      hwdata <= req_wdata;
    end
  end

  // Wait counter: cleared while in SEL so it reads 0 in the first WAIT cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
    end else if (state == ST_SEL) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Response capture on the WAIT exit edge; completion wins over timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == ST_WAIT) begin
      if (done) begin
        rsp_err <= 1'b0;
        if (!hwrite) rsp_rdata <= hrdata;
      end else if (timeout) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lsu_master.sv
module tb_ahb_lsu_master;

  localparam int TIMEOUT  = 15;
  localparam int M_NORMAL = 0;
  localparam int M_DEAD   = 1;
  localparam int M_SLOW   = 2;
  localparam int M_LATE   = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_rwtyp = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic        hwrite;
  logic        hsel;
  logic [31:0] hwdata;
  logic        hready = 1'b0;
  logic        hresp = 1'b0;
  logic [31:0] hrdata = 32'hBAD0_BAD0;

  always #5 clk = ~clk;

  ahb_lsu_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_rwtyp(req_rwtyp), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .hwrite(hwrite), .hsel(hsel), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  typedef struct {
    int          scyc;
    int          rcyc;
    logic [31:0] haddr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_sel[$];
  exp_t exp_rsp[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int slv_mode = M_NORMAL;
  logic [31:0] slv_data = '0;
  int k = 63;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Slave model: k counts cycles since the hsel pulse (k=1 is the first WAIT cycle)
  always @(negedge clk) begin
    if (hsel) k = 0;
    else if (k < 63) k = k + 1;
    hready = 1'b0;
    hresp  = 1'b0;
    hrdata = 32'hBAD0_BAD0;
    case (slv_mode)
      M_NORMAL: begin
        if (hwrite) begin
          if (k == 1) hready = 1'b1;
          if (k == 2) hresp = 1'b1;
        end else if (k == 2) begin
          hready = 1'b1;
          hrdata = slv_data;
        end
      end
      M_SLOW: begin
        if (k == 1 || k == 2) hresp = 1'b1;
        if (k == 3) begin
          hready = 1'b1;
          hrdata = slv_data;
        end
      end
      M_LATE: begin
        if (k == TIMEOUT + 1) begin
          hready = 1'b1;
          hrdata = slv_data;
        end
      end
      default: ;
    endcase
  end

  // Monitor: pops the scoreboard whenever the DUT selects the slave or responds
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (hsel) begin
        if (exp_sel.size() == 0) begin
          check("hsel_unexpected", 32'(hsel), 32'd0);
        end else begin
          e = exp_sel.pop_front();
          check("hsel_cycle", 32'(cyc), 32'(e.scyc));
          check("sel_haddr", haddr, e.haddr);
          check("sel_hwrite", 32'(hwrite), 32'(e.we));
          if (e.we) check("sel_hwdata", hwdata, e.wdata);
          check("sel_req_ready", 32'(req_ready), 32'd0);
        end
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_cycle", 32'(cyc), 32'(e.rcyc));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("resp_haddr", haddr, e.haddr);
          check("resp_hwrite", 32'(hwrite), 32'(e.we));
          if (e.we) check("resp_hwdata", hwdata, e.wdata);
          check("resp_req_ready", 32'(req_ready), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] typ,
                       input logic [31:0] wdata, input logic [31:0] exp_haddr,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("issue_ready_timeout", 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_rwtyp = typ;
    req_wdata = wdata;
    e.scyc  = cyc + 1;
    e.rcyc  = cyc + lat;
    e.haddr = exp_haddr;
    e.we    = we;
    e.wdata = wdata;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_sel.push_back(e);
    exp_rsp.push_back(e);
    @(posedge clk);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    req_valid = 1'b0;
    while ((exp_rsp.size() != 0 || exp_sel.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_rsp.size() != 0 || exp_sel.size() != 0) begin
      check("drain_timeout", 32'(exp_rsp.size() + exp_sel.size()), 32'd0);
      exp_rsp.delete();
      exp_sel.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hsel"}, 32'(hsel), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_haddr"}, haddr, 32'd0);
    check({tag, "_hwrite"}, 32'(hwrite), 32'd0);
    check({tag, "_hwdata"}, hwdata, 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Load word: type 010 lands in haddr[29:27]
    slv_mode = M_NORMAL;
    slv_data = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_0010, 3'b010, 32'h0, 32'h1000_0010, 32'hDEAD_BEEF, 1'b0, 4);
    drain();

    // Store byte: hready pulse in cycle 2 must be ignored; rdata unchanged
    issue(1'b1, 32'h0000_0020, 3'b000, 32'h1234_5678, 32'h0000_0020, 32'hDEAD_BEEF, 1'b0, 4);
    drain();

    // Address bits [29:27] replaced by rwtyp, upper/lower bits kept
    slv_data = 32'h0000_8001;
    issue(1'b0, 32'hF7FF_FFFC, 3'b101, 32'h0, 32'hEFFF_FFFC, 32'h0000_8001, 1'b0, 4);
    drain();

    // Unresponsive slave: timeout after counter reaches TIMEOUT
    slv_mode = M_DEAD;
    issue(1'b0, 32'h0000_0030, 3'b010, 32'h0, 32'h1000_0030, 32'h0, 1'b1, TIMEOUT + 3);
    drain();

    // Write after a timeout clears rsp_err and leaves rdata at 0
    slv_mode = M_NORMAL;
    issue(1'b1, 32'h0000_0034, 3'b001, 32'hCAFE_F00D, 32'h0800_0034, 32'h0, 1'b0, 4);
    drain();

    // Read with hresp raised early: completion only on hready
    slv_mode = M_SLOW;
    slv_data = 32'h5A5A_A5A5;
    issue(1'b0, 32'h0000_0040, 3'b010, 32'h0, 32'h1000_0040, 32'h5A5A_A5A5, 1'b0, 5);
    drain();

    // Completion in the same cycle as timeout counts as completion
    slv_mode = M_LATE;
    slv_data = 32'h0F0F_F0F0;
    issue(1'b0, 32'h0000_0044, 3'b110, 32'h0, 32'h3000_0044, 32'h0F0F_F0F0, 1'b0, TIMEOUT + 3);
    drain();

    // Back-to-back with req_valid held high: one transfer per 5 cycles
    slv_mode = M_NORMAL;
    slv_data = 32'h1111_2222;
    issue(1'b0, 32'h0000_0050, 3'b010, 32'h0, 32'h1000_0050, 32'h1111_2222, 1'b0, 4);
    issue(1'b1, 32'h0000_0054, 3'b010, 32'hA0A0_0505, 32'h1000_0054, 32'h1111_2222, 1'b0, 4);
    issue(1'b0, 32'h0000_0058, 3'b100, 32'h0, 32'h2000_0058, 32'h1111_2222, 1'b0, 4);
    drain();

    // Reset during WAIT: outputs clear at once and the request is dropped
    slv_mode = M_DEAD;
    issue(1'b0, 32'h0000_0060, 3'b010, 32'h0, 32'h1000_0060, 32'h0, 1'b1, TIMEOUT + 3);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1 check_reset_outputs("midreset");
    exp_rsp.delete();
    exp_sel.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Normal operation resumes after reset
    slv_mode = M_NORMAL;
    slv_data = 32'h7777_8888;
    issue(1'b0, 32'h0000_0070, 3'b010, 32'h0, 32'h1000_0070, 32'h7777_8888, 1'b0, 4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
